// File: rtl/riscv_state_pkg.sv
// Shared PMP types, CSR addresses, privilege encodings and the cfg legaliser.
package riscv_state_pkg;

  typedef enum logic [1:0] {
    PMP_OFF   = 2'b00,
    PMP_TOR   = 2'b01,
    PMP_NA4   = 2'b10,
    PMP_NAPOT = 2'b11
  } pmp_a_t;

  typedef struct packed {
    logic       l;
    logic [1:0] rsvd;
    pmp_a_t     a;
    logic       x;
    logic       w;
    logic       r;
  } pmpcfg_t;

  localparam logic [11:0] PMPCFG0  = 12'h3A0;
  localparam logic [11:0] PMPADDR0 = 12'h3B0;

  localparam logic [1:0] PRV_U = 2'b00;
  localparam logic [1:0] PRV_S = 2'b01;
  localparam logic [1:0] PRV_M = 2'b11;

  localparam int PMP_MAX = 16;

  // Reserved bits always read zero, and the reserved write-only combination
  // (w=1, r=0) is turned into no write permission.
  function automatic pmpcfg_t pmpcfg_legalize(input pmpcfg_t c);
    pmpcfg_t o;
    o      = c;
    o.rsvd = 2'b00;
    if (c.w && !c.r) o.w = 1'b0;
    return o;
  endfunction

endpackage

// File: rtl/riscv_pmp_csr.sv
// M-mode PMP CSR file: pmpcfg0..3 / pmpaddr0..15 with WARL legalisation,
// L-bit locking, and a one-cycle registered request/response port.
module riscv_pmp_csr
  import riscv_state_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int PLEN    = (XLEN == 32) ? 34 : 56,
  parameter int PMP_CNT = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [1:0]                        st_prv_i,
  input  logic                              csr_req_i,
  input  logic                              csr_we_i,
  input  logic [11:0]                       csr_adr_i,
  input  logic [XLEN-1:0]                   csr_wdata_i,
  output logic                              csr_ack_o,
  output logic [XLEN-1:0]                   csr_rdata_o,
  output logic                              csr_illegal_o,
  output logic                              pmp_update_o,
  output pmpcfg_t [PMP_CNT-1:0]             st_pmpcfg_o,
  output logic [PMP_CNT-1:0][XLEN-1:0]      st_pmpaddr_o
);

  localparam int AW    = PLEN - 2;
  localparam int BYTES = XLEN / 8;

  // Full 16-entry view; unimplemented entries are tied to zero so they read 0.
  pmpcfg_t [PMP_MAX-1:0]          cfg_q;
  logic    [PMP_MAX-1:0][AW-1:0]  addr_q;
  logic    [PMP_MAX-1:0]          cfg_chg;
  logic    [PMP_MAX-1:0]          addr_chg;

  logic            is_cfg, is_addr, hit, illegal, wr_ok;
  logic [1:0]      cfg_idx;
  logic [3:0]      addr_idx;
  logic [4:0]      ent;
  logic [XLEN-1:0] rdata;

  assign cfg_idx  = csr_adr_i[1:0];
  assign addr_idx = csr_adr_i[3:0];
  assign is_cfg   = (csr_adr_i[11:2] == PMPCFG0[11:2]);
  assign is_addr  = (csr_adr_i[11:4] == PMPADDR0[11:4]);
  assign hit      = is_cfg | is_addr;
  assign illegal  = (st_prv_i != PRV_M) | ((XLEN == 64) & is_cfg & cfg_idx[0]);
  assign wr_ok    = csr_req_i & csr_we_i & hit & ~illegal;

  // Read mux: cfg registers pack one byte per entry, addr registers zero-extend.
  always_comb begin
    rdata = '0;
    ent   = '0;
    if (is_cfg) begin
      for (int j = 0; j < BYTES; j++) begin
        ent = {1'b0, cfg_idx, 2'b00} + 5'(j);
        if (!ent[4]) rdata[8*j +: 8] = cfg_q[ent[3:0]];
      end
    end else if (is_addr) begin
      rdata = XLEN'(addr_q[addr_idx]);
    end
  end

  for (genvar e = 0; e < PMP_MAX; e++) begin : g_entry
    localparam int         J = e % BYTES;
    localparam logic [1:0] K = 2'((e / BYTES) * (BYTES / 4));

    if (e < PMP_CNT) begin : g_impl
      pmpcfg_t         cfg_r, cfg_new;
      logic [AW-1:0]   addr_r, addr_new;
      logic            cfg_we, addr_we, addr_lock;

      assign cfg_new  = pmpcfg_legalize(pmpcfg_t'(csr_wdata_i[8*J +: 8]));
      assign addr_new = csr_wdata_i[AW-1:0];

      // A locked TOR entry above also protects this entry's address, since it
      // forms the bottom of that locked range.
      if (e + 1 < PMP_MAX) begin : g_tor
        assign addr_lock = cfg_r.l | (cfg_q[e+1].l & (cfg_q[e+1].a == PMP_TOR));
      end else begin : g_last
        assign addr_lock = cfg_r.l;
      end

      assign cfg_we   = wr_ok & is_cfg  & (cfg_idx == K)      & ~cfg_r.l;
      assign addr_we  = wr_ok & is_addr & (addr_idx == 4'(e)) & ~addr_lock;
      assign cfg_chg[e]  = cfg_we  & (cfg_new  != cfg_r);
      assign addr_chg[e] = addr_we & (addr_new != addr_r);

      // Entry storage; once L is set only reset clears it.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          cfg_r  <= '0;
          addr_r <= '0;
        end else begin
          if (cfg_we)  cfg_r  <= cfg_new;
          if (addr_we) addr_r <= addr_new;
        end
      end

      assign cfg_q[e]        = cfg_r;
      assign addr_q[e]       = addr_r;
      assign st_pmpcfg_o[e]  = cfg_r;
      assign st_pmpaddr_o[e] = XLEN'(addr_r);
    end else begin : g_none
      assign cfg_q[e]    = '0;
      assign addr_q[e]   = '0;
      assign cfg_chg[e]  = 1'b0;
      assign addr_chg[e] = 1'b0;
    end
  end

  // Response stage: ack/illegal/rdata and the change pulse for the request of the previous cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      csr_ack_o     <= 1'b0;
      csr_illegal_o <= 1'b0;
      csr_rdata_o   <= '0;
      pmp_update_o  <= 1'b0;
    end else begin
      csr_ack_o     <= csr_req_i & hit;
      csr_illegal_o <= csr_req_i & hit & illegal;
      csr_rdata_o   <= (csr_req_i & hit & ~illegal) ? rdata : '0;
      pmp_update_o  <= |{cfg_chg, addr_chg};
    end
  end

endmodule

// File: tb/tb_riscv_pmp_csr.sv
// Directed bench for riscv_pmp_csr: RV32 full, RV64 full and RV32 with 4 entries.
module tb_riscv_pmp_csr;
  import riscv_state_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  prv = PRV_M;
  logic        we  = 1'b0;
  logic [11:0] adr = '0;
  logic [63:0] wdata = '0;
  logic        req32 = 1'b0, req64 = 1'b0, req4 = 1'b0;

  logic                    ack32, ill32, upd32;
  logic [31:0]             rd32;
  pmpcfg_t [15:0]          cfg32;
  logic [15:0][31:0]       pa32;

  logic                    ack64, ill64, upd64;
  logic [63:0]             rd64;
  pmpcfg_t [15:0]          cfg64;
  logic [15:0][63:0]       pa64;

  logic                    ack4, ill4, upd4;
  logic [31:0]             rd4;
  pmpcfg_t [3:0]           cfg4;
  logic [3:0][31:0]        pa4;

  logic        ack_s, ill_s, upd_s;
  logic [63:0] rd_s;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  riscv_pmp_csr #(.XLEN(32), .PMP_CNT(16)) dut32 (
    .clk_i(clk), .rst_i(rst), .st_prv_i(prv), .csr_req_i(req32), .csr_we_i(we),
    .csr_adr_i(adr), .csr_wdata_i(wdata[31:0]), .csr_ack_o(ack32), .csr_rdata_o(rd32),
    .csr_illegal_o(ill32), .pmp_update_o(upd32), .st_pmpcfg_o(cfg32), .st_pmpaddr_o(pa32));

  riscv_pmp_csr #(.XLEN(64), .PMP_CNT(16)) dut64 (
    .clk_i(clk), .rst_i(rst), .st_prv_i(prv), .csr_req_i(req64), .csr_we_i(we),
    .csr_adr_i(adr), .csr_wdata_i(wdata), .csr_ack_o(ack64), .csr_rdata_o(rd64),
    .csr_illegal_o(ill64), .pmp_update_o(upd64), .st_pmpcfg_o(cfg64), .st_pmpaddr_o(pa64));

  riscv_pmp_csr #(.XLEN(32), .PMP_CNT(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .st_prv_i(prv), .csr_req_i(req4), .csr_we_i(we),
    .csr_adr_i(adr), .csr_wdata_i(wdata[31:0]), .csr_ack_o(ack4), .csr_rdata_o(rd4),
    .csr_illegal_o(ill4), .pmp_update_o(upd4), .st_pmpcfg_o(cfg4), .st_pmpaddr_o(pa4));

  // One comparison: counts it, and on mismatch counts and reports the failure.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issues one request to the selected instance and captures its response a cycle later.
  task automatic applyStimulus(input int sel, input logic w, input logic [11:0] a,
                               input logic [63:0] d);
    we    = w;
    adr   = a;
    wdata = d;
    req32 = (sel == 32);
    req64 = (sel == 64);
    req4  = (sel == 4);
    @(posedge clk);
    #1;
    req32 = 1'b0;
    req64 = 1'b0;
    req4  = 1'b0;
    we    = 1'b0;
    case (sel)
      32:      begin ack_s = ack32; ill_s = ill32; upd_s = upd32; rd_s = {32'h0, rd32}; end
      64:      begin ack_s = ack64; ill_s = ill64; upd_s = upd64; rd_s = rd64; end
      default: begin ack_s = ack4;  ill_s = ill4;  upd_s = upd4;  rd_s = {32'h0, rd4}; end
    endcase
  endtask

  task automatic expectResp(input string tag, input logic a, input logic il, input logic u,
                            input logic [63:0] rd);
    checkOutput({tag, "_ack"},   {63'h0, ack_s}, {63'h0, a});
    checkOutput({tag, "_ill"},   {63'h0, ill_s}, {63'h0, il});
    checkOutput({tag, "_upd"},   {63'h0, upd_s}, {63'h0, u});
    checkOutput({tag, "_rdata"}, rd_s, rd);
  endtask

  // Directed sequence with hand-computed expectations.
  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_ack32", {63'h0, ack32}, 64'h0);
    checkOutput("rst_rd32",  {32'h0, rd32},  64'h0);
    checkOutput("rst_ill64", {63'h0, ill64}, 64'h0);
    checkOutput("rst_upd4",  {63'h0, upd4},  64'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset state readback
    applyStimulus(32, 1'b0, 12'h3A0, 64'h0);          expectResp("t1_cfg0", 1, 0, 0, 64'h0);
    applyStimulus(32, 1'b0, 12'h3B3, 64'h0);          expectResp("t1_addr3", 1, 0, 0, 64'h0);
    checkOutput("t1_stcfg",  {63'h0, |cfg32}, 64'h0);
    checkOutput("t1_staddr", {63'h0, |pa32},  64'h0);

    // WARL: w without r stores nothing new
    applyStimulus(32, 1'b1, 12'h3A0, 64'h2);          expectResp("t2_wonly", 1, 0, 0, 64'h0);
    applyStimulus(32, 1'b0, 12'h3A0, 64'h0);          expectResp("t2_rd", 1, 0, 0, 64'h0);

    // Lock on entry 0
    applyStimulus(32, 1'b1, 12'h3B0, 64'h1000);       expectResp("t3_a0", 1, 0, 1, 64'h0);
    applyStimulus(32, 1'b1, 12'h3A0, 64'h9F);         expectResp("t3_lock", 1, 0, 1, 64'h0);
    checkOutput("t3_stcfg0", {56'h0, cfg32[0]}, 64'h9F);
    checkOutput("t3_staddr0", {32'h0, pa32[0]}, 64'h1000);
    applyStimulus(32, 1'b1, 12'h3B0, 64'h1234);       expectResp("t3_a0lk", 1, 0, 0, 64'h1000);
    applyStimulus(32, 1'b1, 12'h3A0, 64'h0);          expectResp("t3_c0lk", 1, 0, 0, 64'h9F);
    applyStimulus(32, 1'b0, 12'h3B0, 64'h0);          expectResp("t3_rda", 1, 0, 0, 64'h1000);
    applyStimulus(32, 1'b0, 12'h3A0, 64'h0);          expectResp("t3_rdc", 1, 0, 0, 64'h9F);

    // Lock on entry 1 (TOR), partial cfg writes, TOR protecting the entry below
    applyStimulus(32, 1'b1, 12'h3A0, 64'h8D9F);       expectResp("t4_c1", 1, 0, 1, 64'h9F);
    applyStimulus(32, 1'b1, 12'h3B0, 64'h55);         expectResp("t4_a0", 1, 0, 0, 64'h1000);
    applyStimulus(32, 1'b1, 12'h3B1, 64'h66);         expectResp("t4_a1", 1, 0, 0, 64'h0);
    applyStimulus(32, 1'b1, 12'h3A0, 64'h8800_8D9F);  expectResp("t4_c3", 1, 0, 1, 64'h8D9F);
    applyStimulus(32, 1'b1, 12'h3B2, 64'h77);         expectResp("t4_a2tor", 1, 0, 0, 64'h0);
    applyStimulus(32, 1'b0, 12'h3B2, 64'h0);          expectResp("t4_rda2", 1, 0, 0, 64'h0);
    applyStimulus(32, 1'b1, 12'h3A0, 64'h006E_8D9F);  expectResp("t4_c2", 1, 0, 1, 64'h8800_8D9F);
    applyStimulus(32, 1'b0, 12'h3A0, 64'h0);          expectResp("t4_rdc", 1, 0, 0, 64'h880C_8D9F);
    checkOutput("t4_stcfg2", {56'h0, cfg32[2]}, 64'h0C);

    // Privilege check and unmapped address
    prv = PRV_U;
    applyStimulus(32, 1'b1, 12'h3B4, 64'hAB);         expectResp("t5_user", 1, 1, 0, 64'h0);
    prv = PRV_M;
    applyStimulus(32, 1'b0, 12'h3B4, 64'h0);          expectResp("t5_rda4", 1, 0, 0, 64'h0);
    applyStimulus(32, 1'b0, 12'h3A4, 64'h0);          expectResp("t5_unmap", 0, 0, 0, 64'h0);

    // RV64: odd pmpcfg illegal, 8 entries per cfg, pmpaddr truncated to 54 bits
    applyStimulus(64, 1'b0, 12'h3A1, 64'h0);          expectResp("t5_odd64", 1, 1, 0, 64'h0);
    applyStimulus(64, 1'b1, 12'h3A0, 64'h8D00_0000_0000_0000);
    expectResp("t5_c7_64", 1, 0, 1, 64'h0);
    checkOutput("t5_stcfg7_64", {56'h0, cfg64[7]}, 64'h8D);
    applyStimulus(64, 1'b1, 12'h3B0, 64'hFFFF_FFFF_FFFF_FFFF);
    expectResp("t5_a0_64", 1, 0, 1, 64'h0);
    applyStimulus(64, 1'b0, 12'h3B0, 64'h0);          expectResp("t5_rda0_64", 1, 0, 0, 64'h003F_FFFF_FFFF_FFFF);

    // Four implemented entries: upper entries ignore writes, back-to-back forwarding
    applyStimulus(4, 1'b1, 12'h3B5, 64'hFF);          expectResp("t6_a5", 1, 0, 0, 64'h0);
    applyStimulus(4, 1'b0, 12'h3B5, 64'h0);           expectResp("t6_rda5", 1, 0, 0, 64'h0);
    applyStimulus(4, 1'b1, 12'h3A1, 64'hFFFF_FFFF);   expectResp("t6_c1", 1, 0, 0, 64'h0);
    applyStimulus(4, 1'b0, 12'h3A1, 64'h0);           expectResp("t6_rdc1", 1, 0, 0, 64'h0);
    applyStimulus(4, 1'b1, 12'h3B0, 64'hCAFE);        expectResp("t6_b2b_w", 1, 0, 1, 64'h0);
    applyStimulus(4, 1'b0, 12'h3B0, 64'h0);           expectResp("t6_b2b_r", 1, 0, 0, 64'hCAFE);
    applyStimulus(4, 1'b0, 12'h3B3, 64'h0);           expectResp("t6_idle", 1, 0, 0, 64'h0);
    @(posedge clk);
    #1;
    checkOutput("t6_noack", {63'h0, ack4}, 64'h0);

    // Reset asserted while a request is pending drops its ack and clears locks
    we    = 1'b0;
    adr   = 12'h3A0;
    req32 = 1'b1;
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    req32 = 1'b0;
    checkOutput("t7_rstack", {63'h0, ack32}, 64'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(32, 1'b0, 12'h3A0, 64'h0);          expectResp("t7_cfgclr", 1, 0, 0, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
